// File: rtl/lvt_multi_regfile_pkg.sv
// Shared types and helpers for the LVT multi-port register file.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lvt_multi_regfile_pkg;

    // Init sequencer states: SWEEP writes INIT_VALUE one entry per cycle, READY serves traffic
    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // LVT entry width: enough bits to name a write port, never narrower than 1
    function automatic int lvt_width(input int nwrite);
        return (nwrite > 1) ? clog2(nwrite) : 1;
    endfunction

endpackage

// File: rtl/lvt_bank.sv
// One 1W1R storage bank: DEPTH x WIDTH, synchronous write, asynchronous read.
// Latency: write visible after the next rising edge; read is combinational.
// Backpressure: none; every asserted write is committed.
module lvt_bank
    import lvt_multi_regfile_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Storage is deliberately unreset; the init sweep gives it a defined value
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Commit the single write port at the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lvt_multi_regfile.sv
// Multi-write multi-read register file built from 1W1R banks plus a live-value table.
// Latency: reads combinational (optional same-cycle forwarding); writes commit at the edge.
// Backpressure: io_ready low during the post-reset init sweep; writes are dropped then.
module lvt_multi_regfile
    import lvt_multi_regfile_pkg::*;
#(
    parameter int               NREAD      = 2,
    parameter int               NWRITE     = 2,
    parameter int               WIDTH      = 4,
    parameter int               DEPTH      = 4,
    parameter int               BYPASS     = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREAD*clog2(DEPTH)-1:0]   io_rp_idx,
    output logic [NREAD*WIDTH-1:0]          io_rp_data,
    input  logic [NWRITE*clog2(DEPTH)-1:0]  io_wp_idx,
    input  logic [NWRITE-1:0]               io_wp_en,
    input  logic [NWRITE*WIDTH-1:0]         io_wp_data,
    output logic                            io_ready,
    output logic                            io_wr_collision
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = lvt_width(NWRITE);

    init_state_e      state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    lvt_q [DEPTH];
    logic [LW-1:0]    lvt_d [DEPTH];
    logic             coll_q, coll_d;
    logic             ready;

    logic [AW-1:0]    wp_idx  [NWRITE];
    logic [WIDTH-1:0] wp_data [NWRITE];
    logic [AW-1:0]    rp_idx  [NREAD];
    logic [NWRITE-1:0] wp_acc;
    logic [NWRITE-1:0] wp_win;

    logic [NWRITE-1:0] bank_we;
    logic [AW-1:0]     bank_waddr [NWRITE];
    logic [WIDTH-1:0]  bank_wdata [NWRITE];
    logic [WIDTH-1:0]  bank_rd    [NWRITE][NREAD];

    // Unpack the flat port buses into per-port lanes
    always_comb begin
        for (int w = 0; w < NWRITE; w++) begin
            wp_idx[w]  = io_wp_idx[w*AW +: AW];
            wp_data[w] = io_wp_data[w*WIDTH +: WIDTH];
        end
        for (int r = 0; r < NREAD; r++) begin
            rp_idx[r] = io_rp_idx[r*AW +: AW];
        end
    end

    // State register: FSM, sweep counter, LVT and the collision pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            coll_q  <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                lvt_q[d] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            lvt_q   <= lvt_d;
        end
    end

    // Next state: walk every entry once, then stay in READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = SWEEP;
        endcase
    end

    // FSM output: ready only once the sweep has covered the whole table
    always_comb begin
        ready = (state_q == READY);
    end

    assign io_ready        = ready;
    assign io_wr_collision = coll_q;

    // Accepted writes, and the winner per index (a higher port shadows a lower one)
    always_comb begin
        wp_acc = io_wp_en & {NWRITE{ready}};
        wp_win = wp_acc;
        coll_d = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            for (int j = i + 1; j < NWRITE; j++) begin
                if (wp_acc[i] && wp_acc[j] && (wp_idx[i] == wp_idx[j])) begin
                    wp_win[i] = 1'b0;
                    coll_d    = 1'b1;
                end
            end
        end
    end

    // Bank column write ports; during the sweep column 0 is taken over for init
    always_comb begin
        for (int w = 0; w < NWRITE; w++) begin
            bank_we[w]    = wp_win[w];
            bank_waddr[w] = wp_idx[w];
            bank_wdata[w] = wp_data[w];
        end
        if (!ready) begin
            bank_we[0]    = 1'b1;
            bank_waddr[0] = cnt_q;
            bank_wdata[0] = INIT_VALUE;
        end
    end

    // LVT update: ascending port order lets the highest accepted port win
    always_comb begin
        lvt_d = lvt_q;
        if (!ready) begin
            lvt_d[cnt_q] = '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (wp_acc[w]) begin
                    lvt_d[wp_idx[w]] = LW'(w);
                end
            end
        end
    end

    // Bank grid: column w holds port w's writes, row r serves read port r
    for (genvar gw = 0; gw < NWRITE; gw++) begin : g_col
        for (genvar gr = 0; gr < NREAD; gr++) begin : g_row
            lvt_bank #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gw]),
                .waddr (bank_waddr[gw]),
                .wdata (bank_wdata[gw]),
                .raddr (rp_idx[gr]),
                .rdata (bank_rd[gw][gr])
            );
        end
    end

    // Read mux: LVT picks the bank column, optional forwarding of this cycle's winner
    always_comb begin
        logic [WIDTH-1:0] rd;
        io_rp_data = '0;
        for (int r = 0; r < NREAD; r++) begin
            rd = '0;
            for (int w = 0; w < NWRITE; w++) begin
                if (lvt_q[rp_idx[r]] == LW'(w)) begin
                    rd = bank_rd[w][r];
                end
            end
            if (BYPASS != 0) begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (wp_win[w] && (wp_idx[w] == rp_idx[r])) begin
                        rd = wp_data[w];
                    end
                end
            end
            if (ready) begin
                io_rp_data[r*WIDTH +: WIDTH] = rd;
            end
        end
    end

endmodule

// File: tb/tb_lvt_multi_regfile.sv
// Testbench for lvt_multi_regfile: three instances (defaults, bypass, wide) against a behavioural model.
module tb_lvt_multi_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Default instance
    logic [3:0]  def_rp_idx;
    logic [7:0]  def_rp_data;
    logic [3:0]  def_wp_idx;
    logic [1:0]  def_wp_en;
    logic [7:0]  def_wp_data;
    logic        def_ready, def_coll;

    // Bypass instance, non-zero init value
    logic [3:0]  byp_rp_idx;
    logic [7:0]  byp_rp_data;
    logic [3:0]  byp_wp_idx;
    logic [1:0]  byp_wp_en;
    logic [7:0]  byp_wp_data;
    logic        byp_ready, byp_coll;

    // Wide instance: 3 read, 4 write, 16 x 8
    logic [11:0] big_rp_idx;
    logic [23:0] big_rp_data;
    logic [15:0] big_wp_idx;
    logic [3:0]  big_wp_en;
    logic [31:0] big_wp_data;
    logic        big_ready, big_coll;

    lvt_multi_regfile u_def (
        .clk (clk), .reset (rst_n),
        .io_rp_idx (def_rp_idx), .io_rp_data (def_rp_data),
        .io_wp_idx (def_wp_idx), .io_wp_en (def_wp_en), .io_wp_data (def_wp_data),
        .io_ready (def_ready), .io_wr_collision (def_coll)
    );

    lvt_multi_regfile #(.BYPASS(1), .INIT_VALUE(4'h9)) u_byp (
        .clk (clk), .reset (rst_n),
        .io_rp_idx (byp_rp_idx), .io_rp_data (byp_rp_data),
        .io_wp_idx (byp_wp_idx), .io_wp_en (byp_wp_en), .io_wp_data (byp_wp_data),
        .io_ready (byp_ready), .io_wr_collision (byp_coll)
    );

    lvt_multi_regfile #(.NREAD(3), .NWRITE(4), .WIDTH(8), .DEPTH(16), .INIT_VALUE(8'h5A)) u_big (
        .clk (clk), .reset (rst_n),
        .io_rp_idx (big_rp_idx), .io_rp_data (big_rp_data),
        .io_wp_idx (big_wp_idx), .io_wp_en (big_wp_en), .io_wp_data (big_wp_data),
        .io_ready (big_ready), .io_wr_collision (big_coll)
    );

    task automatic randomize_all(input logic [1:0] den, input logic [1:0] ben, input logic [3:0] gen);
        def_wp_en   = den;
        def_wp_idx  = 4'($urandom);
        def_wp_data = 8'($urandom);
        def_rp_idx  = 4'($urandom);
        byp_wp_en   = ben;
        byp_wp_idx  = 4'($urandom);
        byp_wp_data = 8'($urandom);
        byp_rp_idx  = 4'($urandom);
        big_wp_en   = gen;
        big_wp_idx  = 16'($urandom);
        big_wp_data = $urandom;
        big_rp_idx  = 12'($urandom);
    endtask

    // Called just after reset release at a falling edge: follows the sweep with writes held on
    task automatic check_sweep(input string tag);
        logic exp_small, exp_big;
        logic [1:0] a2;
        logic [3:0] a4;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            exp_small = (k >= 4);
            exp_big   = (k >= 16);
            checks++;
            if (def_ready !== exp_small) begin
                failures++;
                $display("FAIL %s def_ready cycle %0d: got %b expected %b", tag, k, def_ready, exp_small);
            end
            checks++;
            if (byp_ready !== exp_small) begin
                failures++;
                $display("FAIL %s byp_ready cycle %0d: got %b expected %b", tag, k, byp_ready, exp_small);
            end
            checks++;
            if (big_ready !== exp_big) begin
                failures++;
                $display("FAIL %s big_ready cycle %0d: got %b expected %b", tag, k, big_ready, exp_big);
            end
            if (!exp_small) begin
                checks++;
                if (def_rp_data !== 8'h00 || byp_rp_data !== 8'h00) begin
                    failures++;
                    $display("FAIL %s read_zero_small cycle %0d: got %h/%h expected 00", tag, k, def_rp_data, byp_rp_data);
                end
            end
            if (!exp_big) begin
                checks++;
                if (big_rp_data !== 24'h0) begin
                    failures++;
                    $display("FAIL %s read_zero_big cycle %0d: got %h expected 000000", tag, k, big_rp_data);
                end
            end
            randomize_all(exp_small ? 2'b00 : 2'b11, exp_small ? 2'b00 : 2'b11, exp_big ? 4'h0 : 4'hF);
        end
        // Nothing written while the sweep ran: every entry holds the init value
        for (int i = 0; i < 16; i++) begin
            a2 = 2'(i);
            a4 = 4'(i);
            def_rp_idx = {a2, a2};
            byp_rp_idx = {a2, a2};
            big_rp_idx = {a4, a4, a4};
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (def_rp_data !== 8'h00) begin
                    failures++;
                    $display("FAIL %s def_init idx %0d: got %h expected 00", tag, i, def_rp_data);
                end
                checks++;
                if (byp_rp_data !== 8'h99) begin
                    failures++;
                    $display("FAIL %s byp_init idx %0d: got %h expected 99", tag, i, byp_rp_data);
                end
            end
            checks++;
            if (big_rp_data !== 24'h5A5A5A) begin
                failures++;
                $display("FAIL %s big_init idx %0d: got %h expected 5a5a5a", tag, i, big_rp_data);
            end
        end
    endtask

    task automatic test_reset();
        randomize_all(2'b11, 2'b11, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (def_ready !== 1'b0 || big_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset ready: got %b/%b expected 0/0", def_ready, big_ready);
        end
        checks++;
        if (def_coll !== 1'b0 || big_coll !== 1'b0) begin
            failures++;
            $display("FAIL reset collision: got %b/%b expected 0/0", def_coll, big_coll);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_sweep("reset");
    endtask

    task automatic test_reset_mid_sweep();
        randomize_all(2'b11, 2'b11, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (def_ready !== 1'b0 || big_ready !== 1'b0) begin
            failures++;
            $display("FAIL midsweep ready_in_reset: got %b/%b expected 0/0", def_ready, big_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep("midsweep");
    endtask

    task automatic test_parallel_write();
        @(posedge clk); #1;
        def_wp_idx  = {2'd2, 2'd1};
        def_wp_data = {4'h5, 4'hA};
        def_wp_en   = 2'b11;
        @(posedge clk); #1;
        def_wp_en  = 2'b00;
        def_rp_idx = {2'd2, 2'd1};
        #2;
        checks++;
        if (def_rp_data !== 8'h5A) begin
            failures++;
            $display("FAIL parallel_write data: got %h expected 5a", def_rp_data);
        end
        checks++;
        if (def_coll !== 1'b0) begin
            failures++;
            $display("FAIL parallel_write collision: got %b expected 0", def_coll);
        end
    endtask

    task automatic test_collision();
        def_wp_idx  = {2'd3, 2'd3};
        def_wp_data = {4'hC, 4'h3};
        def_wp_en   = 2'b11;
        @(posedge clk); #1;
        def_wp_en  = 2'b00;
        def_rp_idx = {2'd3, 2'd3};
        #2;
        checks++;
        if (def_rp_data !== 8'hCC) begin
            failures++;
            $display("FAIL collision winner: got %h expected cc", def_rp_data);
        end
        checks++;
        if (def_coll !== 1'b1) begin
            failures++;
            $display("FAIL collision pulse: got %b expected 1", def_coll);
        end
        @(posedge clk); #2;
        checks++;
        if (def_coll !== 1'b0) begin
            failures++;
            $display("FAIL collision pulse_end: got %b expected 0", def_coll);
        end
    endtask

    task automatic test_bypass();
        def_wp_idx  = {2'd3, 2'd0};
        def_wp_data = {4'h0, 4'h7};
        def_wp_en   = 2'b01;
        def_rp_idx  = {2'd1, 2'd0};
        byp_wp_idx  = {2'd3, 2'd0};
        byp_wp_data = {4'h0, 4'h7};
        byp_wp_en   = 2'b01;
        byp_rp_idx  = {2'd1, 2'd0};
        #2;
        checks++;
        if (def_rp_data !== 8'hA0) begin
            failures++;
            $display("FAIL nobypass same_cycle: got %h expected a0", def_rp_data);
        end
        checks++;
        if (byp_rp_data !== 8'h97) begin
            failures++;
            $display("FAIL bypass same_cycle: got %h expected 97", byp_rp_data);
        end
        @(posedge clk); #2;
        def_wp_en = 2'b00;
        #1;
        checks++;
        if (def_rp_data !== 8'hA7) begin
            failures++;
            $display("FAIL nobypass after_edge: got %h expected a7", def_rp_data);
        end
        byp_wp_idx  = {2'd0, 2'd0};
        byp_wp_data = {4'h2, 4'h1};
        byp_wp_en   = 2'b11;
        byp_rp_idx  = {2'd0, 2'd1};
        #1;
        checks++;
        if (byp_rp_data !== 8'h29) begin
            failures++;
            $display("FAIL bypass collision_fwd: got %h expected 29", byp_rp_data);
        end
        @(posedge clk); #1;
        byp_wp_en = 2'b00;
        #1;
        checks++;
        if (byp_rp_data !== 8'h29 || byp_coll !== 1'b1) begin
            failures++;
            $display("FAIL bypass collision_commit: got data %h coll %b expected 29 1", byp_rp_data, byp_coll);
        end
    endtask

    task automatic reset_to_ready(input string tag);
        def_wp_en = 2'b00;
        byp_wp_en = 2'b00;
        big_wp_en = 4'h0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if (byp_ready !== 1'b1 || big_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_after_reset: got %b/%b expected 1/1", tag, byp_ready, big_ready);
        end
    endtask

    task automatic test_random_bypass();
        logic [3:0] mem [4];
        logic [3:0] nxt [4];
        logic       exp_coll, coll_now;
        logic [1:0] ia, ib;
        logic [3:0] exp_d;
        reset_to_ready("rand_byp");
        for (int i = 0; i < 4; i++) mem[i] = 4'h9;
        exp_coll = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            byp_wp_en   = 2'($urandom);
            byp_wp_idx  = 4'($urandom);
            byp_wp_data = 8'($urandom);
            byp_rp_idx  = 4'($urandom);
            #2;
            nxt = mem;
            for (int w = 0; w < 2; w++) begin
                if (byp_wp_en[w]) nxt[byp_wp_idx[w*2 +: 2]] = byp_wp_data[w*4 +: 4];
            end
            ia = byp_wp_idx[1:0];
            ib = byp_wp_idx[3:2];
            coll_now = (byp_wp_en == 2'b11) && (ia == ib);
            for (int r = 0; r < 2; r++) begin
                exp_d = nxt[byp_rp_idx[r*2 +: 2]];
                checks++;
                if (byp_rp_data[r*4 +: 4] !== exp_d) begin
                    failures++;
                    $display("FAIL rand_byp read cycle %0d port %0d: got %h expected %h", c, r, byp_rp_data[r*4 +: 4], exp_d);
                end
            end
            checks++;
            if (byp_coll !== exp_coll) begin
                failures++;
                $display("FAIL rand_byp collision cycle %0d: got %b expected %b", c, byp_coll, exp_coll);
            end
            mem = nxt;
            @(posedge clk); #1;
            exp_coll = coll_now;
        end
        byp_wp_en = 2'b00;
    endtask

    task automatic test_random_big();
        logic [7:0] mem [16];
        logic       exp_coll, coll_now;
        logic [7:0] exp_d;
        reset_to_ready("rand_big");
        for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
        exp_coll = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            big_wp_en   = 4'($urandom);
            big_wp_idx  = 16'($urandom);
            big_wp_data = $urandom;
            big_rp_idx  = 12'($urandom);
            #2;
            for (int r = 0; r < 3; r++) begin
                exp_d = mem[big_rp_idx[r*4 +: 4]];
                checks++;
                if (big_rp_data[r*8 +: 8] !== exp_d) begin
                    failures++;
                    $display("FAIL rand_big read cycle %0d port %0d: got %h expected %h", c, r, big_rp_data[r*8 +: 8], exp_d);
                end
            end
            checks++;
            if (big_coll !== exp_coll) begin
                failures++;
                $display("FAIL rand_big collision cycle %0d: got %b expected %b", c, big_coll, exp_coll);
            end
            coll_now = 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if (big_wp_en[i] && big_wp_en[j] && big_wp_idx[i*4 +: 4] == big_wp_idx[j*4 +: 4]) coll_now = 1'b1;
                end
            end
            for (int w = 0; w < 4; w++) begin
                if (big_wp_en[w]) mem[big_wp_idx[w*4 +: 4]] = big_wp_data[w*8 +: 8];
            end
            @(posedge clk); #1;
            exp_coll = coll_now;
        end
        big_wp_en = 4'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        randomize_all(2'b00, 2'b00, 4'h0);
        test_reset();
        test_reset_mid_sweep();
        test_parallel_write();
        test_collision();
        test_bypass();
        test_random_bypass();
        test_random_big();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvt_multi_regfile.md
LVT_MULTI_REGFILE -- requirements
Module: lvt_multi_regfile

Interface
REQ-001 Parameter NREAD, default 2: number of read ports, 1..8.
REQ-002 Parameter NWRITE, default 2: number of write ports, 1..4.
REQ-003 Parameter WIDTH, default 4: data bits per entry.
REQ-004 Parameter DEPTH, default 4: entry count, power of two, at least 2; AW = clog2(DEPTH).
REQ-005 Parameter BYPASS, default 0: 1 = same-cycle write-to-read forwarding.
REQ-006 Parameter INIT_VALUE, default 0: WIDTH-bit value every entry holds after the init sweep.
REQ-007 clk  in  1  the single clock, rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 io_rp_idx  in  NREAD*AW  read addresses, port r at bits [r*AW +: AW].
REQ-010 io_rp_data  out  NREAD*WIDTH  read data, port r at bits [r*WIDTH +: WIDTH].
REQ-011 io_wp_idx  in  NWRITE*AW  write addresses, packed the same way.
REQ-012 io_wp_en  in  NWRITE  per-port write enables.
REQ-013 io_wp_data  in  NWRITE*WIDTH  write data, packed the same way.
REQ-014 io_ready  out  1  high once the init sweep completes; writes are accepted only while high.
REQ-015 io_wr_collision  out  1  registered pulse: in the previous cycle, two or more enabled write ports targeted the same index.

Function
REQ-016 Storage: NWRITE x NREAD banks, each 1W1R, DEPTH x WIDTH; write port w writes all NREAD banks in column w; read port r reads bank (LVT[idx], r).
REQ-017 LVT: DEPTH entries of clog2(NWRITE) bits in flops (width 1 when NWRITE = 1, tied 0); an accepted write on port w sets LVT[idx] = w at the same edge as the bank write.
REQ-018 Read latency 0: io_rp_data is combinational from io_rp_idx and the state at the last edge.
REQ-019 When io_ready is low, every io_rp_data lane is driven to 0.
REQ-020 A write is accepted at a rising edge when io_ready = 1 and io_wp_en[w] = 1; io_wp_en is ignored while io_ready = 0.
REQ-021 Write collision (several accepted ports, same index): the highest-numbered port wins both the bank write and the LVT update; io_wr_collision = 1 for exactly the next cycle.
REQ-022 Different indices on different ports in one cycle are all committed.
REQ-023 BYPASS = 0: a read of an index written this cycle returns the old value.
REQ-024 BYPASS = 1: a read of an index written this cycle returns the winning port's io_wp_data.
REQ-025 Init FSM states: SWEEP (counter 0..DEPTH-1; writes INIT_VALUE to bank column 0, all rows, and LVT[counter] = 0; one entry per cycle) and READY; SWEEP -> READY after entry DEPTH-1 is written.
REQ-026 io_ready rises DEPTH cycles after reset deassertion.
REQ-027 A valid-index read of any entry returns the last accepted write to it, or INIT_VALUE if none; this is equivalent to a flop regfile with the same priority rule.

Reset
REQ-028 reset low: FSM = SWEEP, counter = 0, io_ready = 0, io_wr_collision = 0, LVT = 0; bank contents are not reset.
REQ-029 reset asserted mid-sweep or in READY: immediate return to the REQ-028 state; the sweep restarts from entry 0 after deassertion.

Structure
REQ-030 Package lvt_multi_regfile_pkg SHALL hold the clog2 function, the FSM state typedef (SWEEP, READY) and the LVT entry width function.
REQ-031 One sub-module, lvt_bank: parametrised 1W1R memory with asynchronous read and no reset, instantiated NWRITE*NREAD times.

Verification
REQ-032 Defaults; reset low 3 cycles, then high -> io_ready = 0 for 4 cycles, then 1; all reads return 0 while not ready and INIT_VALUE afterwards.
REQ-033 Port 0 writes idx 1 = 0xA; port 1 writes idx 2 = 0x5 in the same cycle -> next cycle, rp0 idx 1 = 0xA, rp1 idx 2 = 0x5, io_wr_collision = 0.
REQ-034 Both ports write idx 3 (port 0 0x3, port 1 0xC) -> idx 3 reads 0xC and io_wr_collision pulses for one cycle.
REQ-035 BYPASS = 1: port 0 writes idx 0 = 0x7 while rp0 reads idx 0 -> rp0 = 0x7 in the same cycle; with BYPASS = 0 it returns the prior value.
REQ-036 reset pulsed low at sweep count 2; io_wp_en held high throughout the sweep -> sweep restarts, io_ready rises DEPTH cycles after deassertion, and no write is committed before that.
REQ-037 NREAD = 3, NWRITE = 4, DEPTH = 16, WIDTH = 8: 10k random cycles -> lockstep match against a flop regfile reference, and a formal equivalence proof against the same model from the reset state.
